// File: rtl/i_ram_loader.sv
// i_ram_loader: boot-time instruction RAM writer.
// Receives a framed byte stream (sync, LEN_LO, LEN_HI, LEN x {lo, hi}, CHK)
// from the UART receiver and writes 16-bit words into the instruction RAM.
// The CPU is held in reset until the image's checksum matches.
// Optional feature: define LOADER_TIMEOUT_EN to abort a stalled frame after
// timeout_cycles idle clocks (otherwise a stalled frame waits indefinitely).
module i_ram_loader #(
    parameter int unsigned addr_width     = 12,
    parameter logic [7:0]  sync_byte      = 8'h55,
    parameter int unsigned timeout_cycles = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [addr_width-1:0] w_addr,
    output logic [15:0]           din,
    output logic                  w_en,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [addr_width:0]   words_loaded
);

    localparam int unsigned CNT_W    = addr_width + 1;
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned CAPACITY = 1 << addr_width;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [7:0]              lo_q, lo_d;
    logic [7:0]              sum_q, sum_d;
    logic [CNT_W-1:0]        words_q, words_d;
    logic [addr_width-1:0]   w_addr_q, w_addr_d;
    logic [15:0]             din_q, din_d;
    logic                    w_en_q, w_en_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic [LEN_W-1:0]        len_full_c;
    logic [CNT_W-1:0]        words_inc_c;

    assign len_full_c  = {rx_data, len_lo_q};
    assign words_inc_c = words_q + CNT_W'(1);

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Inter-byte idle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            lo_q      <= '0;
            sum_q     <= '0;
            words_q   <= '0;
            w_addr_q  <= '0;
            din_q     <= '0;
            w_en_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            lo_q      <= lo_d;
            sum_q     <= sum_d;
            words_q   <= words_d;
            w_addr_q  <= w_addr_d;
            din_q     <= din_d;
            w_en_q    <= w_en_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Frame parser: next state, word assembly, checksum and write strobe.
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        lo_d      = lo_q;
        sum_d     = sum_q;
        words_d   = words_q;
        w_addr_d  = w_addr_q;
        din_d     = din_q;
        w_en_d    = 1'b0;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (rx_valid) begin
            case (state_q)
                IDLE, ERROR: begin
                    if (rx_data == sync_byte) begin
                        state_d = LEN_LO;
                        sum_d   = '0;
                        words_d = '0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    if ({1'b0, len_full_c} > 17'(CAPACITY)) begin
                        state_d = ERROR;
                    end else if (len_full_c == '0) begin
                        state_d = CHECK;
                    end else begin
                        len_d   = CNT_W'(len_full_c);
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: begin
                    lo_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    sum_d    = sum_q + rx_data;
                    w_en_d   = 1'b1;
                    w_addr_d = words_q[addr_width-1:0];
                    din_d    = {rx_data, lo_q};
                    words_d  = words_inc_c;
                    state_d  = (words_inc_c == len_q) ? CHECK : DATA_LO;
                end
                CHECK: begin
                    state_d = (rx_data == sum_q) ? DONE : ERROR;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

`ifdef LOADER_TIMEOUT_EN
        // Only in-frame states age; any received byte restarts the count.
        tmo_d = '0;
        if (!rx_valid && (state_q == LEN_LO || state_q == LEN_HI ||
                          state_q == DATA_LO || state_q == DATA_HI ||
                          state_q == CHECK)) begin
            if (tmo_q == TMO_W'(timeout_cycles - 1)) begin
                state_d = ERROR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        done_d    = (state_d == DONE);
        error_d   = (state_d == ERROR);
        cpu_rst_d = (state_d != DONE);
    end

    assign w_addr       = w_addr_q;
    assign din          = din_q;
    assign w_en         = w_en_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_i_ram_loader.sv
// Testbench for i_ram_loader: cycle-by-cycle vector table plus a stall
// sequence whose expectation depends on LOADER_TIMEOUT_EN.
module tb_i_ram_loader;

    localparam int unsigned AW = 12;

`ifdef LOADER_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic          w_en;
        logic [AW-1:0] w_addr;
        logic [15:0]   din;
        logic [AW:0]   words;
        logic          done;
        logic          error;
        logic          cpu_rst;
    } out_t;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        out_t       exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] w_addr;
    logic [15:0]   din;
    logic          w_en;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int   errors = 0;
    int   checks = 0;
    int   wr_seen = 0;
    vec_t vecs[$];

    i_ram_loader #(
        .addr_width     (AW),
        .sync_byte      (8'h55),
        .timeout_cycles (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .w_addr       (w_addr),
        .din          (din),
        .w_en         (w_en),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write pulses across the whole run.
    always @(negedge clk) begin
        if (w_en === 1'b1) wr_seen++;
    end

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic we, input logic [AW-1:0] a, input logic [15:0] dn,
                       input logic [AW:0] w, input logic dne, input logic er, input logic cr);
        vec_t x;
        x.rst  = r;
        x.vld  = v;
        x.data = d;
        x.exp  = '{w_en: we, w_addr: a, din: dn, words: w, done: dne, error: er, cpu_rst: cr};
        vecs.push_back(x);
    endtask

    // Idle-state expectation shortcut.
    task automatic add_r(input logic r, input logic v, input logic [7:0] d);
        add(r, v, d, 1'b0, '0, 16'h0000, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step(input string name, input logic r, input logic v,
                        input logic [7:0] d, input out_t exp);
        out_t act;
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        act = {w_en, w_addr, din, words_loaded, done, error, cpu_rst};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got w_en=%b w_addr=%h din=%h words=%0d done=%b error=%b cpu_rst=%b, expected w_en=%b w_addr=%h din=%h words=%0d done=%b error=%b cpu_rst=%b",
                     name, act.w_en, act.w_addr, act.din, act.words, act.done, act.error, act.cpu_rst,
                     exp.w_en, exp.w_addr, exp.din, exp.words, exp.done, exp.error, exp.cpu_rst);
        end
    endtask

    initial begin
        out_t idle_o;
        out_t stall_o;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle_o   = '{w_en: 1'b0, w_addr: '0, din: 16'h0000, words: '0, done: 1'b0, error: 1'b0, cpu_rst: 1'b1};

        // Reset state
        add_r(1, 0, 8'h00);
        // Nominal back-to-back load of two words
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h02);
        add_r(0, 1, 8'h00);
        add_r(0, 1, 8'h34);
        add  (0, 1, 8'h12, 1, 12'd0, 16'h1234, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h78, 0, 12'd0, 16'h1234, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h56, 1, 12'd1, 16'h5678, 13'd2, 0, 0, 1);
        add  (0, 1, 8'h14, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        // DONE is terminal: a new frame is ignored
        add  (0, 1, 8'h55, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        add  (0, 1, 8'h01, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        add  (0, 1, 8'h00, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        add  (0, 1, 8'hCD, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        add  (0, 1, 8'hAB, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        add  (0, 0, 8'h00, 0, 12'd1, 16'h5678, 13'd2, 1, 0, 0);
        // Reset beats a coincident sync byte; then noise ignored in IDLE
        add_r(1, 1, 8'h55);
        add_r(0, 1, 8'hAA);
        add_r(0, 1, 8'h00);
        // Bad checksum: word stays written, CPU held
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h01);
        add_r(0, 1, 8'h00);
        add_r(0, 1, 8'hCD);
        add  (0, 1, 8'hAB, 1, 12'd0, 16'hABCD, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h00, 0, 12'd0, 16'hABCD, 13'd1, 0, 1, 1);
        // Resend from ERROR: sync clears error and word count
        add  (0, 1, 8'h55, 0, 12'd0, 16'hABCD, 13'd0, 0, 0, 1);
        add  (0, 1, 8'h01, 0, 12'd0, 16'hABCD, 13'd0, 0, 0, 1);
        add  (0, 1, 8'h00, 0, 12'd0, 16'hABCD, 13'd0, 0, 0, 1);
        add  (0, 1, 8'hCD, 0, 12'd0, 16'hABCD, 13'd0, 0, 0, 1);
        add  (0, 1, 8'hAB, 1, 12'd0, 16'hABCD, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h78, 0, 12'd0, 16'hABCD, 13'd1, 1, 0, 0);
        // Oversize length 4097 -> ERROR straight after LEN_HI
        add_r(1, 0, 8'h00);
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h01);
        add  (0, 1, 8'h10, 0, 12'd0, 16'h0000, 13'd0, 0, 1, 1);
        add  (0, 1, 8'h22, 0, 12'd0, 16'h0000, 13'd0, 0, 1, 1);
        // Empty frame out of ERROR
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h00);
        add_r(0, 1, 8'h00);
        add  (0, 1, 8'h00, 0, 12'd0, 16'h0000, 13'd0, 1, 0, 0);
        // Reset mid-frame between lo and hi bytes of word 3
        add_r(1, 0, 8'h00);
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h04);
        add_r(0, 1, 8'h00);
        add_r(0, 1, 8'h11);
        add  (0, 1, 8'h22, 1, 12'd0, 16'h2211, 13'd1, 0, 0, 1);
        add  (0, 0, 8'h99, 0, 12'd0, 16'h2211, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h33, 0, 12'd0, 16'h2211, 13'd1, 0, 0, 1);
        add  (0, 1, 8'h44, 1, 12'd1, 16'h4433, 13'd2, 0, 0, 1);
        add  (0, 1, 8'h55, 0, 12'd1, 16'h4433, 13'd2, 0, 0, 1);
        add  (0, 1, 8'h66, 1, 12'd2, 16'h6655, 13'd3, 0, 0, 1);
        add  (0, 1, 8'h77, 0, 12'd2, 16'h6655, 13'd3, 0, 0, 1);
        add_r(1, 1, 8'h88);
        // Fresh frame after reset loads from address 0
        add_r(0, 1, 8'h55);
        add_r(0, 1, 8'h01);
        add_r(0, 1, 8'h00);
        add_r(0, 1, 8'hEF);
        add  (0, 1, 8'hBE, 1, 12'd0, 16'hBEEF, 13'd1, 0, 0, 1);
        add  (0, 1, 8'hAD, 0, 12'd0, 16'hBEEF, 13'd1, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].exp);
        end

        // Stall in LEN_HI: times out only when the feature is built in
        step("tmo_rst", 1'b1, 1'b0, 8'h00, idle_o);
        step("tmo_sync", 1'b0, 1'b1, 8'h55, idle_o);
        step("tmo_len_lo", 1'b0, 1'b1, 8'h02, idle_o);
        for (int i = 0; i < 16; i++) begin
            stall_o = idle_o;
            stall_o.error = (i == 15) ? TMO_EN : 1'b0;
            step($sformatf("stall%0d", i), 1'b0, 1'b0, 8'h00, stall_o);
        end

        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_seen != 8) begin
            errors++;
            $display("FAIL write_count: got %0d, expected 8", wr_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_ram_loader.md
Name: i_ram_loader

Overview:
- Boot-time writer for the instruction RAM: consumes a byte stream from the UART receiver and assembles 16-bit instruction words.
- Drives the instruction RAM write port (w_addr/din/w_en) and holds the CPU in reset until a complete, checksum-verified image has been written.
- Sits between the UART rx block and the instruction RAM write port; the RAM read port stays with the CPU fetch path.

Parameters:
- addr_width, 12, instruction RAM address width; capacity = 1<<addr_width words.
- sync_byte, 8'h55, frame start marker.
- timeout_cycles, 1000000, inter-byte timeout in clk cycles; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte, valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- w_addr  output  addr_width  RAM write address.
- din  output  16  RAM write data, {hi_byte, lo_byte}.
- w_en  output  1  RAM write enable, one-cycle pulse per word.
- cpu_rst  output  1  active-high CPU reset; held high until the load completes.
- done  output  1  image loaded and verified.
- error  output  1  frame rejected.
- words_loaded  output  addr_width+1  count of words written in the current frame.

Behaviour:
- Frame format: sync_byte, LEN_LO, LEN_HI, then LEN words each sent low byte then high byte, then one CHK byte. CHK = 8-bit sum (mod 256) of all data bytes only; length bytes are excluded.
- Reset values: w_addr=0, din=0, w_en=0, cpu_rst=1, done=0, error=0, words_loaded=0, state=IDLE.
- States and transitions:
  - IDLE: rx byte == sync_byte -> LEN_LO; other bytes are ignored.
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8].
    - len > (1<<addr_width) -> ERROR.
    - len == 0 -> CHECK.
    - otherwise -> DATA_LO.
  - DATA_LO: latch lo byte; add it to sum -> DATA_HI.
  - DATA_HI: add byte to sum. On the next cycle: w_en=1 for exactly one cycle, w_addr=words_loaded (pre-increment value), din={byte, lo}; words_loaded increments in that same cycle. Then -> DATA_LO if more words remain, else -> CHECK.
  - CHECK: rx byte == sum[7:0] -> DONE, else -> ERROR.
  - DONE: done=1, cpu_rst=0 from the cycle after the CHK byte is accepted. rx_valid is ignored; the state is terminal until rst.
  - ERROR: error=1, cpu_rst=1. On rx byte == sync_byte -> LEN_LO, clearing error, sum and words_loaded in the same cycle.
- Latency: every state advances only on rx_valid. A word write is visible on the RAM port 1 cycle after the rx_valid of its high byte.
- Back-to-back rx_valid on every cycle must be sustained with no byte lost.
- Words written before a failed checksum remain in RAM; the CPU stays in reset.
- sum and words_loaded clear when the sync byte is accepted.
- cpu_rst stays high in IDLE, LEN_*, DATA_*, CHECK and ERROR.
- rst asserted mid-frame: return to reset values on the next edge and discard the partial frame. A w_en due on that edge is suppressed.
- w_addr and din hold their last values when w_en=0.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A counter runs in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK, and clears on each rx_valid.
  - When it reaches timeout_cycles-1 with no byte received -> ERROR.
  - IDLE, DONE and ERROR never time out.
- LOADER_TIMEOUT_EN not defined: no counter is synthesized; a stalled frame waits indefinitely.

Test Plan:
- Nominal load: bytes 55,02,00,34,12,78,56,14 sent back-to-back -> writes addr0=16'h1234 and addr1=16'h5678, one w_en pulse each; words_loaded=2; done=1 and cpu_rst=0 the cycle after byte 14; error=0.
- Bad checksum: 55,01,00,CD,AB,00 -> one write, addr0=16'hABCD; error=1, cpu_rst=1, done=0. Then resend 55,01,00,CD,AB,78 -> error clears, done=1.
- Oversize and empty frames:
  - 55,01,10 (len=4097, addr_width=12) -> ERROR immediately after LEN_HI, no w_en.
  - 55,00,00,00 -> done=1 with zero writes.
- Noise and post-done behaviour: bytes AA,00 before 55 are ignored. After DONE, a further 55,01,00,... produces no w_en and no state change.
- Reset mid-frame: rst asserted between the lo and hi bytes of word 3 -> all outputs at reset values next cycle, no write to addr3. A following fresh frame loads correctly starting at addr0.
- LOADER_TIMEOUT_EN with timeout_cycles=16: send 55,02 then stall 16 cycles -> error=1. The same stall without the macro leaves error=0 and the state stays LEN_HI.
